// File: rtl/simplex_tx_init_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simplex_tx_init_ctrl_pkg
// Purpose  : Shared types and sizing helpers for the simplex TX init
//            controller: encoder symbol classes, init FSM states, lane count.
// Revision : 1.0 - initial release
// ============================================================================
package simplex_tx_init_ctrl_pkg;

  // Lane count of the channel; lane_select and lane_en are one bit per lane.
  localparam int MAX_LINKS      = 2;
  localparam int MAX_LINKS_SIZE = MAX_LINKS;

  // Symbol class requested from the ordered-sets encoder.
  typedef enum logic [2:0] {
    OS_IDLE = 3'd0,
    OS_K    = 3'd1,
    OS_A    = 3'd2,
    OS_V    = 3'd3,
    OS_CC   = 3'd4,
    OS_DATA = 3'd5
  } os_sel_t;

  // Lane initialisation sequence.
  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_BOND   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_READY  = 3'd4
  } init_state_t;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/simplex_tx_init_ctrl_cc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : simplex_tx_init_ctrl_cc_scheduler
// Purpose  : Clock-compensation burst scheduler. A period counter runs while
//            the channel is out of reset; each time it reaches zero a burst
//            of CC_LEN consecutive CC cycles starts. clear (asserted when the
//            next cycle is a reset cycle) zeroes both counters and aborts any
//            burst in progress.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            clear            - next cycle belongs to ST_RESET
//            cc_next          - CC flag for the coming cycle (combinational)
//            cc_active        - CC flag for the current cycle (registered)
// Revision : 1.0 - initial release
// ============================================================================
module simplex_tx_init_ctrl_cc_scheduler
  import simplex_tx_init_ctrl_pkg::*;
#(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic cc_next,
  output logic cc_active
);

  localparam int PW = cnt_width(CC_PERIOD - 1);
  localparam int BW = cnt_width(CC_LEN - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(CC_PERIOD - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(CC_LEN - 1);

  // running: current cycle is outside ST_RESET, so the period counter is live.
  logic          running;
  logic [PW-1:0] period_cnt;
  logic [PW-1:0] period_d;
  // burst_left: CC cycles still owed after the current one.
  logic [BW-1:0] burst_left;
  logic [BW-1:0] burst_d;

  always_comb begin
    period_d = '0;
    burst_d  = '0;
    cc_next  = 1'b0;
    if (!clear) begin
      // The first cycle after reset sees a period count of zero, so a burst
      // opens immediately on leaving ST_RESET.
      if (running) begin
        period_d = (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
      end
      if (period_d == '0) begin
        cc_next = 1'b1;
        burst_d = BURST_LAST;
      end else if (burst_left != '0) begin
        cc_next = 1'b1;
        burst_d = burst_left - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running    <= 1'b0;
      period_cnt <= '0;
      burst_left <= '0;
      cc_active  <= 1'b0;
    end else begin
      running    <= !clear;
      period_cnt <= period_d;
      burst_left <= burst_d;
      cc_active  <= cc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/simplex_tx_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : simplex_tx_init_ctrl
// Purpose  : Transmit-side Aurora simplex channel controller. Sequences lane
//            init (reset, /K/ align, /A/ bond, /V/ verify, ready) and, once
//            ready, arbitrates the encoder between CC bursts, user data and
//            idle fill. All outputs are registered and change on the same
//            edge as the state they describe.
// Build    : define SIMPLEX_TIMER_EN to replace the aligned/bonded/verified
//            sideband handshake with fixed state durations (ALIGN_CYCLES,
//            BOND_CYCLES); simplex_reset is still honoured.
// Ports    : clk, rst_n             - clock, synchronous active-low reset
//            single_lane            - single-lane channel (bonding skipped)
//            lane_select            - one-hot active lane in single-lane mode
//            simplex_aligned/bonded/verified/reset - receiver sideband
//            axi_valid              - upstream data valid
//            axi_ready              - encoder accepts data this cycle
//            tx_os_sel              - symbol class for the encoder
//            lane_en                - per-lane transmit enable
//            channel_init_finished  - channel ready
//            init_state             - current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module simplex_tx_init_ctrl
  import simplex_tx_init_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 8,
  parameter int VERIFY_CNT   = 64,
  parameter int CC_PERIOD    = 5000,
  parameter int CC_LEN       = 6,
  parameter int ALIGN_CYCLES = 128,
  parameter int BOND_CYCLES  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      single_lane,
  input  logic [MAX_LINKS_SIZE-1:0] lane_select,
  input  logic                      simplex_aligned,
  input  logic                      simplex_bonded,
  input  logic                      simplex_verified,
  input  logic                      simplex_reset,
  input  logic                      axi_valid,
  output logic                      axi_ready,
  output os_sel_t                   tx_os_sel,
  output logic [MAX_LINKS-1:0]      lane_en,
  output logic                      channel_init_finished,
  output init_state_t               init_state
);

  if (RESET_CYCLES < 1 || VERIFY_CNT < 1 || CC_LEN < 1 || CC_LEN >= CC_PERIOD ||
      ALIGN_CYCLES < 1 || BOND_CYCLES < 1) begin : g_param_check
    $error("simplex_tx_init_ctrl: illegal parameter set");
  end

  localparam int RW = cnt_width(RESET_CYCLES - 1);
  localparam int VW = cnt_width(VERIFY_CNT);
  localparam logic [RW-1:0] RST_LAST    = RW'(RESET_CYCLES - 1);
  localparam logic [VW-1:0] VERIFY_DONE = VW'(VERIFY_CNT);

  init_state_t          state;
  init_state_t          next_state;
  logic [RW-1:0]        rst_cnt;
  logic [VW-1:0]        verify_cnt;
  logic [VW-1:0]        verify_inc;
  logic [MAX_LINKS-1:0] lane_mask;
  logic [MAX_LINKS-1:0] mask_d;
  logic                 single_latched;
  logic                 single_d;
  logic                 rst_last;
  logic                 mask_bad;
  logic                 cc_next;
  logic                 cc_active;

  // Progress conditions for each init step, either sideband or timer driven.
  logic                 align_go;
  logic                 bond_go;
  logic                 verify_go;
  logic                 aligned_ok;

  os_sel_t              os_d;
  logic [MAX_LINKS-1:0] lane_en_d;
  logic                 ready_d;
  logic                 fin_d;

  assign init_state = state;
  assign rst_last   = (rst_cnt == RST_LAST);
  // A single-lane selection that is not exactly one lane cannot be trained.
  assign mask_bad   = single_lane && !$onehot(lane_select);
  // Mask and mode are captured only on the final reset count.
  assign mask_d     = (state == ST_RESET && rst_last) ?
                      (single_lane ? lane_select : {MAX_LINKS{1'b1}}) : lane_mask;
  assign single_d   = (state == ST_RESET && rst_last) ? single_lane : single_latched;
  // Verify count as it will stand after this cycle: CC cycles carry no /V/,
  // so they do not count towards the minimum.
  assign verify_inc = (!cc_active && verify_cnt != VERIFY_DONE) ?
                      verify_cnt + 1'b1 : verify_cnt;

`ifdef SIMPLEX_TIMER_EN
  localparam int TMAX = (ALIGN_CYCLES > BOND_CYCLES) ? ALIGN_CYCLES : BOND_CYCLES;
  localparam int TW   = cnt_width(TMAX - 1);
  localparam logic [TW-1:0] ALIGN_LAST = TW'(ALIGN_CYCLES - 1);
  localparam logic [TW-1:0] BOND_LAST  = TW'(BOND_CYCLES - 1);

  logic [TW-1:0] state_timer;

  // Cycles spent in the current timed state; stops at the exit count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_timer <= '0;
    end else if (next_state == state && (state == ST_ALIGN || state == ST_BOND)) begin
      state_timer <= state_timer + 1'b1;
    end else begin
      state_timer <= '0;
    end
  end

  assign align_go   = (state_timer == ALIGN_LAST);
  assign bond_go    = (state_timer == BOND_LAST);
  assign verify_go  = 1'b1;
  assign aligned_ok = 1'b1;
`else
  assign align_go   = simplex_aligned;
  assign bond_go    = simplex_bonded;
  assign verify_go  = simplex_verified;
  assign aligned_ok = simplex_aligned;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; simplex_reset overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      ST_RESET: begin
        if (rst_last) begin
          next_state = mask_bad ? ST_RESET : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (align_go) begin
          next_state = single_latched ? ST_VERIFY : ST_BOND;
        end
      end
      ST_BOND: begin
        if (!aligned_ok) begin
          next_state = ST_RESET;
        end else if (bond_go) begin
          next_state = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (!aligned_ok) begin
          next_state = ST_RESET;
        end else if (verify_go && verify_inc == VERIFY_DONE) begin
          next_state = ST_READY;
        end
      end
      ST_READY: begin
        if (!aligned_ok) begin
          next_state = ST_RESET;
        end
      end
      default: next_state = ST_RESET;
    endcase
    if (simplex_reset) begin
      next_state = ST_RESET;
    end
  end

  // Output decode for the coming cycle; registered below so every output
  // changes on the same edge as init_state.
  always_comb begin
    os_d      = OS_IDLE;
    lane_en_d = '0;
    ready_d   = 1'b0;
    fin_d     = 1'b0;
    if (next_state != ST_RESET) begin
      lane_en_d = mask_d;
      fin_d     = (next_state == ST_READY);
      if (cc_next) begin
        os_d = OS_CC;
      end else begin
        case (next_state)
          ST_ALIGN:  os_d = OS_K;
          ST_BOND:   os_d = OS_A;
          ST_VERIFY: os_d = OS_V;
          ST_READY: begin
            os_d    = axi_valid ? OS_DATA : OS_IDLE;
            ready_d = 1'b1;
          end
          default:   os_d = OS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_cnt               <= '0;
      verify_cnt            <= '0;
      lane_mask             <= '0;
      single_latched        <= 1'b0;
      tx_os_sel             <= OS_IDLE;
      lane_en               <= '0;
      axi_ready             <= 1'b0;
      channel_init_finished <= 1'b0;
    end else begin
      // Counts consecutive reset cycles; restarts on a reinit request or
      // after the last count (bad lane mask keeps us here).
      if (state == ST_RESET && next_state == ST_RESET && !rst_last && !simplex_reset) begin
        rst_cnt <= rst_cnt + 1'b1;
      end else begin
        rst_cnt <= '0;
      end
      if (next_state == ST_RESET) begin
        verify_cnt <= '0;
      end else if (state == ST_VERIFY) begin
        verify_cnt <= verify_inc;
      end
      lane_mask             <= mask_d;
      single_latched        <= single_d;
      tx_os_sel             <= os_d;
      lane_en               <= lane_en_d;
      axi_ready             <= ready_d;
      channel_init_finished <= fin_d;
    end
  end

  simplex_tx_init_ctrl_cc_scheduler #(
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN)
  ) u_cc_scheduler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (next_state == ST_RESET),
    .cc_next   (cc_next),
    .cc_active (cc_active)
  );

endmodule
`default_nettype wire

// File: tb/tb_simplex_tx_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_simplex_tx_init_ctrl
// Purpose  : Self-checking bench for simplex_tx_init_ctrl. A driver applies
//            directed and random sideband/data stimulus on the falling edge
//            and pushes the reference model's expected outputs into a queue;
//            a monitor pops one entry per rising edge and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simplex_tx_init_ctrl;
  import simplex_tx_init_ctrl_pkg::*;

  localparam int RESET_CYCLES = 4;
  localparam int VERIFY_CNT   = 4;
  localparam int CC_PERIOD    = 20;
  localparam int CC_LEN       = 2;
  localparam int ALIGN_CYCLES = 8;
  localparam int BOND_CYCLES  = 4;

  logic        clk;
  logic        rst_n;
  logic        single_lane;
  logic [1:0]  lane_select;
  logic        simplex_aligned;
  logic        simplex_bonded;
  logic        simplex_verified;
  logic        simplex_reset;
  logic        axi_valid;
  logic        axi_ready;
  os_sel_t     tx_os_sel;
  logic [1:0]  lane_en;
  logic        channel_init_finished;
  init_state_t init_state;

  simplex_tx_init_ctrl #(
    .RESET_CYCLES (RESET_CYCLES),
    .VERIFY_CNT   (VERIFY_CNT),
    .CC_PERIOD    (CC_PERIOD),
    .CC_LEN       (CC_LEN),
    .ALIGN_CYCLES (ALIGN_CYCLES),
    .BOND_CYCLES  (BOND_CYCLES)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .single_lane           (single_lane),
    .lane_select           (lane_select),
    .simplex_aligned       (simplex_aligned),
    .simplex_bonded        (simplex_bonded),
    .simplex_verified      (simplex_verified),
    .simplex_reset         (simplex_reset),
    .axi_valid             (axi_valid),
    .axi_ready             (axi_ready),
    .tx_os_sel             (tx_os_sel),
    .lane_en               (lane_en),
    .channel_init_finished (channel_init_finished),
    .init_state            (init_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    init_state_t st;
    os_sel_t     os;
    logic [1:0]  lane;
    logic        fin;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: channel phase plus elapsed-cycle bookkeeping.
  init_state_t m_state  = ST_RESET;
  int          m_in_rst = 0;   // cycles spent in reset since last (re)start
  int          m_run    = 0;   // cycles elapsed since leaving reset
  int          m_vseen  = 0;   // /V/ symbols actually emitted in verify
  int          m_age    = 0;   // cycles spent in the current phase
  logic [1:0]  m_mask   = 2'b00;
  logic        m_single = 1'b0;

  function automatic bit cc_at(input init_state_t st, input int run);
    return (st != ST_RESET) && ((run % CC_PERIOD) < CC_LEN);
  endfunction

  task automatic model_step();
    exp_t        e;
    init_state_t nst;
    bit          cc_now;
    bit          cc_new;
    int          v_after;
    cc_now  = cc_at(m_state, m_run);
    v_after = m_vseen;
    if (m_state == ST_VERIFY && !cc_now && m_vseen < VERIFY_CNT) v_after = m_vseen + 1;
    nst = m_state;
    if (!rst_n) begin
      nst      = ST_RESET;
      m_mask   = 2'b00;
      m_single = 1'b0;
    end else if (simplex_reset) begin
      nst = ST_RESET;
    end else begin
      case (m_state)
        ST_RESET: begin
          if (m_in_rst == RESET_CYCLES - 1) begin
            m_single = single_lane;
            m_mask   = single_lane ? lane_select : 2'b11;
            nst = (single_lane && $countones(lane_select) != 1) ? ST_RESET : ST_ALIGN;
          end
        end
`ifdef SIMPLEX_TIMER_EN
        ST_ALIGN:  if (m_age == ALIGN_CYCLES - 1) nst = m_single ? ST_VERIFY : ST_BOND;
        ST_BOND:   if (m_age == BOND_CYCLES - 1) nst = ST_VERIFY;
        ST_VERIFY: if (v_after == VERIFY_CNT) nst = ST_READY;
`else
        ST_ALIGN:  if (simplex_aligned) nst = m_single ? ST_VERIFY : ST_BOND;
        ST_BOND: begin
          if (!simplex_aligned) nst = ST_RESET;
          else if (simplex_bonded) nst = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (!simplex_aligned) nst = ST_RESET;
          else if (simplex_verified && v_after == VERIFY_CNT) nst = ST_READY;
        end
        ST_READY:  if (!simplex_aligned) nst = ST_RESET;
`endif
        default: ;
      endcase
    end
    if (nst == ST_RESET) begin
      if (rst_n && !simplex_reset && m_state == ST_RESET && m_in_rst < RESET_CYCLES - 1)
        m_in_rst = m_in_rst + 1;
      else
        m_in_rst = 0;
      m_vseen = 0;
      m_run   = 0;
    end else begin
      m_run    = (m_state == ST_RESET) ? 0 : m_run + 1;
      m_in_rst = 0;
      if (m_state == ST_VERIFY) m_vseen = v_after;
    end
    m_age   = (nst == m_state) ? m_age + 1 : 0;
    m_state = nst;

    cc_new = cc_at(nst, m_run);
    e.st   = nst;
    e.lane = (nst == ST_RESET) ? 2'b00 : m_mask;
    e.fin  = (nst == ST_READY);
    e.rdy  = (nst == ST_READY) && !cc_new;
    if (nst == ST_RESET)       e.os = OS_IDLE;
    else if (cc_new)           e.os = OS_CC;
    else if (nst == ST_ALIGN)  e.os = OS_K;
    else if (nst == ST_BOND)   e.os = OS_A;
    else if (nst == ST_VERIFY) e.os = OS_V;
    else                       e.os = axi_valid ? OS_DATA : OS_IDLE;
    q.push_back(e);
  endtask

  // Inputs are already set; record the expectation, then advance one cycle.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per rising edge.
  initial begin
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries required 1", $time);
      end else begin
        e = q.pop_front();
        chk("init_state", 8'(init_state), 8'(e.st));
        chk("tx_os_sel", 8'(tx_os_sel), 8'(e.os));
        chk("lane_en", 8'(lane_en), 8'(e.lane));
        chk("channel_init_finished", 8'(channel_init_finished), 8'(e.fin));
        chk("axi_ready", 8'(axi_ready), 8'(e.rdy));
      end
    end
  end

  initial begin
    rst_n = 1'b0; single_lane = 1'b0; lane_select = 2'b00;
    simplex_aligned = 1'b0; simplex_bonded = 1'b0; simplex_verified = 1'b0;
    simplex_reset = 1'b0; axi_valid = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;

    // Single-lane bring-up on lane 1, then continuous data across CC bursts.
    single_lane = 1'b1; lane_select = 2'b10;
    for (int c = 0; c < 60; c++) begin
      simplex_aligned  = (c >= 10);
      simplex_verified = (c >= 16);
      axi_valid        = 1'($urandom_range(0, 1));
      tick();
    end
    axi_valid = 1'b1;
    repeat (45) tick();

    // Reinit pulse in READY, then two-lane bring-up.
    simplex_reset = 1'b1; tick(); simplex_reset = 1'b0;
    single_lane = 1'b0; simplex_aligned = 1'b0; simplex_bonded = 1'b0; simplex_verified = 1'b0;
    for (int c = 0; c < 50; c++) begin
      simplex_aligned  = (c >= 8);
      simplex_bonded   = (c >= 13);
      simplex_verified = (c >= 20);
      axi_valid        = 1'($urandom_range(0, 1));
      tick();
    end

    // Alignment lost during VERIFY.
    simplex_reset = 1'b1; tick(); simplex_reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      simplex_aligned  = (c >= 8 && c < 16) || (c >= 25);
      simplex_bonded   = (c >= 10);
      simplex_verified = (c >= 35);
      axi_valid        = 1'($urandom_range(0, 1));
      tick();
    end

    // Invalid single-lane mask holds reset; a valid one releases it.
    simplex_reset = 1'b1; tick(); simplex_reset = 1'b0;
    single_lane = 1'b1; lane_select = 2'b00;
    repeat (20) tick();
    lane_select = 2'b11;
    repeat (10) tick();
    lane_select = 2'b01;
    repeat (20) tick();

    // Random traffic and sideband behaviour.
    for (int c = 0; c < 3000; c++) begin
      simplex_reset    = ($urandom_range(0, 199) == 0);
      simplex_aligned  = ($urandom_range(0, 49) != 0);
      simplex_bonded   = ($urandom_range(0, 3) == 0);
      simplex_verified = ($urandom_range(0, 3) == 0);
      axi_valid        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        single_lane = 1'($urandom_range(0, 1));
        lane_select = 2'($urandom_range(0, 3));
      end
      tick();
    end

    // Mid-run synchronous reset.
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
